// File: rtl/alu_pkg.sv
// Shared definitions for the multicycle ALU: op-code encodings, FSM state type
// and the op-code width.
package alu_pkg;

    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] OP_AND = 4'b0000;
    localparam logic [ALU_OP_W-1:0] OP_OR  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] OP_ADD = 4'b0010;
    localparam logic [ALU_OP_W-1:0] OP_XOR = 4'b0011;
    localparam logic [ALU_OP_W-1:0] OP_NOR = 4'b0100;
    localparam logic [ALU_OP_W-1:0] OP_SUB = 4'b0110;
    localparam logic [ALU_OP_W-1:0] OP_SLT = 4'b0111;
    localparam logic [ALU_OP_W-1:0] OP_SLL = 4'b1000;
    localparam logic [ALU_OP_W-1:0] OP_SRL = 4'b1001;
    localparam logic [ALU_OP_W-1:0] OP_SRA = 4'b1010;
    localparam logic [ALU_OP_W-1:0] OP_MUL = 4'b1011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial-product step per cycle,
// WIDTH steps per product. product_next is the value the step this cycle produces.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               load,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               step,
    output logic               last,
    output logic [2*WIDTH-1:0] product_next
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   add;

    // The multiplier shifts out of lo as product bits shift in from hi.
    always_comb begin
        add          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        product_next = {add, lo_q[WIDTH-1:1]};
        last         = (cnt_q == CNT_W'(WIDTH - 1));
    end

    // NOTE: every signal written in an always_comb gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        if (load) begin
            mcand_d = a;
            hi_d    = '0;
            lo_d    = b;
            cnt_d   = '0;
        end else if (step) begin
            hi_d  = product_next[2*WIDTH-1:WIDTH];
            lo_d  = product_next[WIDTH-1:0];
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Handshaked, registered ALU with Zero/Carry/Overflow/Illegal flags.
// Define ALU_MUL_EN to build the iterative multiplier for op 1011.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    SrcA,
    input  logic [WIDTH-1:0]    SrcB,
    output logic [WIDTH-1:0]    ALUResult,
    output logic [WIDTH-1:0]    ResultHi,
    output logic                Zero,
    output logic                Carry,
    output logic                Overflow,
    output logic                Illegal,
    output logic                busy,
    output logic                done
);

    localparam int SH_W = $clog2(WIDTH);

    state_e              state_q, state_d;
    logic [ALU_OP_W-1:0] op_q, op_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                ovf_q, ovf_d;
    logic                illegal_q, illegal_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [WIDTH-1:0]    exec_res;
    logic                exec_carry;
    logic                exec_ovf;
    logic                exec_ill;
    logic [WIDTH:0]      sum;
    logic [SH_W-1:0]     sh;

`ifdef ALU_MUL_EN
    logic                mul_load;
    logic                mul_step;
    logic                mul_last;
    logic [2*WIDTH-1:0]  mul_prod;
    logic [WIDTH-1:0]    res_hi_q, res_hi_d;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clock        (clock),
        .reset_n      (reset_n),
        .load         (mul_load),
        .a            (SrcA),
        .b            (SrcB),
        .step         (mul_step),
        .last         (mul_last),
        .product_next (mul_prod)
    );
`endif

    // Single-cycle datapath, evaluated from the operands captured at start.
    always_comb begin
        exec_res   = '0;
        exec_carry = 1'b0;
        exec_ovf   = 1'b0;
        exec_ill   = 1'b0;
        sum        = '0;
        sh         = b_q[SH_W-1:0];
        case (op_q)
            OP_AND: exec_res = a_q & b_q;
            OP_OR:  exec_res = a_q | b_q;
            OP_XOR: exec_res = a_q ^ b_q;
            OP_NOR: exec_res = ~(a_q | b_q);
            OP_ADD: begin
                sum        = {1'b0, a_q} + {1'b0, b_q};
                exec_res   = sum[WIDTH-1:0];
                exec_carry = sum[WIDTH];
                exec_ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SUB: begin
                sum        = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
                exec_res   = sum[WIDTH-1:0];
                exec_carry = sum[WIDTH];
                exec_ovf   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
            end
            OP_SLT: exec_res[0] = ($signed(a_q) < $signed(b_q));
            OP_SLL: exec_res = a_q << sh;
            OP_SRL: exec_res = a_q >> sh;
            OP_SRA: exec_res = $signed(a_q) >>> sh;
            default: exec_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        carry_d   = carry_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef ALU_MUL_EN
        res_hi_d  = res_hi_q;
        mul_load  = 1'b0;
        mul_step  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d    = op;
                    a_d     = SrcA;
                    b_d     = SrcB;
                    busy_d  = 1'b1;
                    state_d = ST_EXEC;
`ifdef ALU_MUL_EN
                    if (op == OP_MUL) begin
                        state_d  = ST_MUL;
                        mul_load = 1'b1;
                    end
`endif
                end
            end
            ST_EXEC: begin
                result_d  = exec_res;
                zero_d    = (exec_res == '0);
                carry_d   = exec_carry;
                ovf_d     = exec_ovf;
                illegal_d = exec_ill;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
`ifdef ALU_MUL_EN
                res_hi_d  = '0;
`endif
            end
`ifdef ALU_MUL_EN
            ST_MUL: begin
                mul_step = 1'b1;
                if (mul_last) begin
                    result_d  = mul_prod[WIDTH-1:0];
                    res_hi_d  = mul_prod[2*WIDTH-1:WIDTH];
                    zero_d    = (mul_prod[WIDTH-1:0] == '0);
                    carry_d   = 1'b0;
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            carry_q   <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            carry_q   <= carry_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef ALU_MUL_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            res_hi_q <= '0;
        end else begin
            res_hi_q <= res_hi_d;
        end
    end
    assign ResultHi = res_hi_q;
`else
    assign ResultHi = '0;
`endif

    assign ALUResult = result_q;
    assign Zero      = zero_q;
    assign Carry     = carry_q;
    assign Overflow  = ovf_q;
    assign Illegal   = illegal_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: doc/multicycle_alu.md
# multicycle_alu

Parametrised, handshaked ALU for the multicycle processor datapath; successor to the fixed 8-bit combinational ALU. Adds start/busy/done handshake, registered results with Zero/Carry/Overflow flags, XOR/NOR/shift operations and an iterative shift-add multiplier. Sits between the register-file operand latches (SrcA/SrcB) and the ALUOut register, and is driven by the control FSM.

## Interface
- WIDTH, 8, operand/result width in bits; must be ≥4 and a power of two.
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  4  operation code (see Operation).
- SrcA  in  WIDTH  operand A; captured on accepted start.
- SrcB  in  WIDTH  operand B; captured on accepted start.
- ALUResult  out  WIDTH  result (MUL: low half); reset 0.
- ResultHi  out  WIDTH  MUL high half, 0 for all other ops; reset 0.
- Zero  out  1  ALUResult == 0; reset 0 (not 1).
- Carry  out  1  ADD carry-out / SUB no-borrow; 0 otherwise; reset 0.
- Overflow  out  1  signed overflow for ADD/SUB; 0 otherwise; reset 0.
- Illegal  out  1  op not implemented; reset 0.
- busy  out  1  high from accepted start until done; reset 0.
- done  out  1  one-cycle pulse when outputs are updated; reset 0.

## Operation
- Encodings: AND 0000, OR 0001, ADD 0010, XOR 0011, NOR 0100, SUB 0110, SLT 0111, SLL 1000, SRL 1001, SRA 1010, MUL 1011; every other code is illegal.
- SLT: signed compare; result 1 if $signed(SrcA) < $signed(SrcB), else 0.
- Shifts: amount = SrcB[log2(WIDTH)-1:0]; upper SrcB bits ignored; SRA replicates MSB.
- ADD/SUB: WIDTH+1-bit internal sum; Carry = bit WIDTH (SUB: 1 means no borrow); Overflow = operand-sign rule.
- MUL: unsigned, 2·WIDTH-bit product; one shift-add step per cycle, WIDTH steps.
- Illegal op: ALUResult = 0, ResultHi = 0, Zero = 1, Illegal = 1, latency 1.
- FSM states: IDLE, EXEC, MUL. IDLE + start: capture op/operands, busy ← 1, go to EXEC (single-cycle ops and illegal) or MUL. EXEC: write outputs, pulse done, busy ← 0, return to IDLE. MUL: count WIDTH steps; on last step write outputs, pulse done, return to IDLE.
- Outputs hold their last value between operations; start outside IDLE is ignored (not queued).
- start is accepted in the same cycle done pulses only if the FSM is in IDLE; done and start never overlap for acceptance.

## Timing
- Single-cycle ops: start accepted at edge N; outputs and done valid after edge N+1 (latency 1).
- MUL: outputs and done valid after edge N+WIDTH (8 cycles at default width).
- Back-to-back throughput: one single-cycle op every 2 cycles.
- Flags update only with done; never combinationally from inputs.
- Reset mid-operation: FSM returns to IDLE immediately, all outputs return to reset values, and the in-flight op is discarded with no done pulse.

## Configuration
- ALU_MUL_EN defined: the multiplier sub-module is instantiated and op 1011 executes MUL as specified.
- ALU_MUL_EN undefined: no multiplier hardware is built, op 1011 is treated as illegal (latency 1, Illegal = 1), and ResultHi is tied to 0.

## Structure
- Shared package alu_pkg: op-code localparams, state enum type, and the ALU_OP_W = 4 constant.
- One sub-module, alu_mul_iter: WIDTH-parameterised shift-add multiplier with load/step/last interface; instantiated only under ALU_MUL_EN.

## Test plan
- ADD 193+25 -> ALUResult 218, Carry 0, Overflow 0, done exactly 1 cycle after start; ADD 248+143 -> 135, Carry 1, Overflow 0.
- SUB 181−181 -> ALUResult 0, Zero 1, Carry 1; SUB 7−19 -> 244, Carry 0.
- SLT 179 vs 45 -> 1; SLT 58 vs 151 -> 0. SRA 0x90 by 2 -> 0xE4; SLL 0x81 by 9 (amount 1) -> 0x02.
- MUL 200×3 -> ALUResult 0x58, ResultHi 0x02, done 8 cycles after start; a second start while busy produces no extra done.
- Reset pulse at cycle 4 of a MUL -> all outputs 0, busy 0, no done; a following ADD 30+31 -> 61 after 1 cycle.
- op 1111 -> ALUResult 0, Illegal 1, Zero 1; without ALU_MUL_EN, op 1011 -> Illegal 1, ResultHi 0.
